// File: rtl/uart_tx_scheduler_if.sv
// rtl/uart_tx_scheduler_if.sv - register-side write port and uart_tx handshake bundle
//
// Signals:
//   wr_en, wr_data      byte write strobe and data from the TX register
//   clr_err             synchronous clear of the sticky error flags
//   tx_busy             busy from uart_tx
//   tx_start, tx_data   start pulse and byte towards uart_tx
//   full, empty, count  FIFO status
//   overflow            sticky, a write was dropped
//   timeout_err         sticky, uart_tx never acknowledged a start
// Modports: slave = scheduler side, master = register / uart_tx side.
interface uart_tx_scheduler_if #(
    parameter int DEPTH = 8
);
    logic                     wr_en;
    logic [7:0]               wr_data;
    logic                     clr_err;
    logic                     tx_busy;
    logic                     tx_start;
    logic [7:0]               tx_data;
    logic                     full;
    logic                     empty;
    logic [$clog2(DEPTH):0]   count;
    logic                     overflow;
    logic                     timeout_err;

    modport slave (
        input  wr_en, wr_data, clr_err, tx_busy,
        output tx_start, tx_data, full, empty, count, overflow, timeout_err
    );

    modport master (
        output wr_en, wr_data, clr_err, tx_busy,
        input  tx_start, tx_data, full, empty, count, overflow, timeout_err
    );
endinterface

// File: rtl/uart_tx_scheduler.sv
// rtl/uart_tx_scheduler.sv - byte FIFO that launches queued bytes into uart_tx
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-low reset
//   bus   uart_tx_scheduler_if.slave (write port, uart_tx handshake, status)
// Parameters:
//   DEPTH         FIFO entries, power of two, 2..64
//   BUSY_TIMEOUT  cycles from tx_start by which tx_busy must have risen
module uart_tx_scheduler #(
    parameter int DEPTH        = 8,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    uart_tx_scheduler_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(BUSY_TIMEOUT + 1);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_LAUNCH    = 2'd1;
    localparam logic [1:0] S_WAIT_BUSY = 2'd2;
    localparam logic [1:0] S_WAIT_DONE = 2'd3;

    logic [1:0]    state;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count_q;
    logic [TW-1:0] tmo_cnt;
    logic [TW-1:0] tmo_next;
    logic [7:0]    tx_data_q;
    logic          overflow_q;
    logic          timeout_q;
    logic          full_w;
    logic          empty_w;
    logic          pop;
    logic          push;
    logic          drop;
    logic          tmo_hit;

    assign full_w  = (count_q == CW'(DEPTH));
    assign empty_w = (count_q == '0);

    // Pop decision uses the registered empty flag, so a byte written this
    // cycle into an empty FIFO can only be popped on the following cycle.
    assign pop  = (state == S_IDLE) && !empty_w && !bus.tx_busy;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign push = bus.wr_en && (!full_w || pop);
    assign drop = bus.wr_en && full_w && !pop;

    // tmo_cnt is cleared in the launch cycle, so after this edge tmo_next + 1
    // cycles have elapsed since tx_start; the flag becomes visible exactly
    // BUSY_TIMEOUT cycles after the start pulse.
    assign tmo_next = tmo_cnt + 1'b1;
    assign tmo_hit  = (state == S_WAIT_BUSY) && !bus.tx_busy &&
                      (tmo_next == TW'(BUSY_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            tmo_cnt    <= '0;
            tx_data_q  <= 8'h00;
            overflow_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr    <= rd_ptr + 1'b1;
                tx_data_q <= mem[rd_ptr];
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase

            // Error events win over a clear in the same cycle.
            if (drop) begin
                overflow_q <= 1'b1;
            end else if (bus.clr_err) begin
                overflow_q <= 1'b0;
            end
            if (tmo_hit) begin
                timeout_q <= 1'b1;
            end else if (bus.clr_err) begin
                timeout_q <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (pop) begin
                        state <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    tmo_cnt <= '0;
                    state   <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    if (bus.tx_busy) begin
                        state <= S_WAIT_DONE;
                    end else if (tmo_hit) begin
                        state <= S_IDLE;
                    end else begin
                        tmo_cnt <= tmo_next;
                    end
                end
                S_WAIT_DONE: begin
                    if (!bus.tx_busy) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.tx_start    = (state == S_LAUNCH);
    assign bus.tx_data     = tx_data_q;
    assign bus.full        = full_w;
    assign bus.empty       = empty_w;
    assign bus.count       = count_q;
    assign bus.overflow    = overflow_q;
    assign bus.timeout_err = timeout_q;
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb/tb_uart_tx_scheduler.sv - randomized self-checking bench with a queue-based reference model
module tb_uart_tx_scheduler;
    localparam int DEPTH = 8;
    localparam int T     = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_tx_scheduler_if #(.DEPTH(DEPTH)) bus ();

    uart_tx_scheduler #(.DEPTH(DEPTH), .BUSY_TIMEOUT(T)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: FIFO contents as a queue, plus where the current
    // transfer stands measured in cycles since its start pulse.
    logic [7:0] m_q[$];
    logic [7:0] m_last;
    bit         m_launch;
    int         m_age;
    bit         m_acked;
    bit         m_ovf;
    bit         m_to;
    int         m_pops;

    // uart_tx responder
    bit hold_busy, resp_noack, resp_random;
    int resp_delay, resp_len;
    int r_delay, r_len;
    int n_starts;
    logic [7:0] tx_log[$];
    int cyc;

    task automatic model_reset();
        m_q.delete();
        m_last = 8'h00; m_launch = 0; m_age = 0; m_acked = 0;
        m_ovf = 0; m_to = 0;
        r_delay = 0; r_len = 0;
    endtask

    task automatic model_step(input bit we, input logic [7:0] wd, input bit clr, input bit busy);
        bit ovf_ev, to_ev;
        ovf_ev = 0; to_ev = 0;
        if (m_launch) begin
            m_launch = 0;
            m_age = 1;
        end else if (m_age >= 1) begin
            if (busy) begin
                m_age = 0; m_acked = 1;
            end else if (m_age + 1 == T) begin
                m_age = 0; to_ev = 1;
            end else begin
                m_age++;
            end
        end else if (m_acked) begin
            if (!busy) m_acked = 0;
        end else if (m_q.size() > 0 && !busy) begin
            m_last = m_q.pop_front();
            m_launch = 1;
            m_pops++;
        end
        if (we) begin
            if (m_q.size() < DEPTH) m_q.push_back(wd);
            else ovf_ev = 1;
        end
        m_ovf = ovf_ev | (m_ovf & !clr);
        m_to  = to_ev  | (m_to  & !clr);
    endtask

    task automatic check_model();
        check("tx_start", bus.tx_start, m_launch);
        check("tx_data", bus.tx_data, m_last);
        check("count", bus.count, m_q.size());
        check("full", bus.full, m_q.size() == DEPTH);
        check("empty", bus.empty, m_q.size() == 0);
        check("overflow", bus.overflow, m_ovf);
        check("timeout_err", bus.timeout_err, m_to);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_tx_start"}, bus.tx_start, 1'b0);
        check({tag, "_tx_data"}, bus.tx_data, 8'h00);
        check({tag, "_empty"}, bus.empty, 1'b1);
        check({tag, "_full"}, bus.full, 1'b0);
        check({tag, "_count"}, bus.count, 0);
        check({tag, "_overflow"}, bus.overflow, 1'b0);
        check({tag, "_timeout_err"}, bus.timeout_err, 1'b0);
    endtask

    // One clock: compare outputs at the falling edge, let the responder react,
    // drive the inputs for the next rising edge and advance the model.
    task automatic cycle(input bit we, input logic [7:0] wd, input bit clr);
        bit b, na;
        @(negedge clk);
        cyc++;
        check_model();
        if (bus.tx_start) begin
            n_starts++;
            tx_log.push_back(bus.tx_data);
            na = resp_noack;
            if (resp_random) begin
                resp_delay = $urandom_range(0, 7);
                resp_len   = $urandom_range(1, 6);
                na = ($urandom_range(0, 9) == 0);
            end
            if (!na) begin
                r_delay = resp_delay;
                r_len   = resp_len;
            end
        end
        if (hold_busy) begin
            b = 1;
        end else if (r_len > 0 && r_delay == 0) begin
            b = 1;
            r_len--;
        end else begin
            b = 0;
            if (r_delay > 0) r_delay--;
        end
        bus.wr_en   = we;
        bus.wr_data = wd;
        bus.clr_err = clr;
        bus.tx_busy = b;
        model_step(we, wd, clr, b);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int s_cyc, te_cyc, n0, k;
        bus.wr_en = 0; bus.wr_data = 0; bus.clr_err = 0; bus.tx_busy = 0;
        hold_busy = 0; resp_noack = 0; resp_random = 0;
        resp_delay = 1; resp_len = 10;
        n_starts = 0; m_pops = 0; cyc = 0;
        model_reset();

        #1 rst = 1'b0;
        #1 check_reset_values("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Single byte, uart_tx answers 2 cycles after start for 10 cycles
        tx_log.delete();
        cycle(1, 8'hA5, 0);
        for (int i = 0; i < 25; i++) cycle(0, 0, 0);
        check("single_starts", n_starts, 1);
        check("single_data", tx_log.size() > 0 ? tx_log[0] : 8'hxx, 8'hA5);
        check("single_empty", bus.empty, 1'b1);

        // Burst with uart_tx held busy, then overflow and clear
        hold_busy = 1;
        n0 = n_starts;
        for (int i = 1; i <= 8; i++) cycle(1, 8'(i), 0);
        cycle(0, 0, 0);
        check("burst_full", bus.full, 1'b1);
        check("burst_count", bus.count, 8);
        check("burst_no_start", n_starts, n0);
        cycle(1, 8'hFF, 0);
        cycle(0, 0, 0);
        check("ovf_set", bus.overflow, 1'b1);
        check("ovf_count", bus.count, 8);
        cycle(0, 0, 1);
        cycle(0, 0, 0);
        check("ovf_clear", bus.overflow, 1'b0);
        tx_log.delete();
        resp_delay = 1; resp_len = 3;
        hold_busy = 0;
        for (int i = 0; i < 150; i++) cycle(0, 0, 0);
        check("order_len", tx_log.size(), 8);
        for (int i = 0; i < 8 && i < tx_log.size(); i++) check("order_byte", tx_log[i], i + 1);

        // Timeout: uart_tx never raises busy
        resp_noack = 1;
        s_cyc = -1; te_cyc = -1;
        for (int i = 0; i < 40; i++) begin
            cycle(i == 0, 8'h3C, 0);
            if (bus.tx_start && s_cyc < 0) s_cyc = cyc;
            if (bus.timeout_err && te_cyc < 0) te_cyc = cyc;
        end
        check("timeout_flag", bus.timeout_err, 1'b1);
        check("timeout_latency", te_cyc - s_cyc, T);
        resp_noack = 0;
        cycle(0, 0, 1);
        tx_log.delete();
        cycle(1, 8'h3D, 0);
        for (int i = 0; i < 30; i++) cycle(0, 0, 0);
        check("after_timeout_len", tx_log.size(), 1);
        check("after_timeout_byte", tx_log.size() > 0 ? tx_log[0] : 8'hxx, 8'h3D);

        // Randomized stream with wraps, back-pressure windows and timeouts
        resp_random = 1;
        for (int i = 0; i < 2500; i++) begin
            if (i % 60 == 0) hold_busy = ($urandom_range(0, 3) == 0);
            cycle($urandom_range(0, 99) < 45, 8'($urandom), $urandom_range(0, 29) == 0);
        end
        resp_random = 0; hold_busy = 0; resp_delay = 0; resp_len = 4;
        for (int i = 0; i < 200; i++) cycle(0, 0, 0);
        check("drain_empty", bus.empty, 1'b1);
        check("start_total", n_starts, m_pops);

        // Reset during WAIT_DONE with bytes still queued
        resp_delay = 0; resp_len = 20;
        for (int i = 0; i < 3; i++) cycle(1, 8'h50 + 8'(i), 0);
        k = 0;
        while (!m_acked && k < 60) begin
            cycle(0, 0, 0);
            k++;
        end
        check("reach_wait_done", m_acked, 1'b1);
        #2 rst = 1'b0;
        #1 check_reset_values("midreset");
        model_reset();
        bus.wr_en = 0; bus.clr_err = 0; bus.tx_busy = 0;
        @(negedge clk);
        rst = 1'b1;
        n0 = n_starts;
        for (int i = 0; i < 40; i++) cycle(0, 0, 0);
        check("post_reset_starts", n_starts, n0);
        cycle(1, 8'h77, 0);
        cycle(0, 0, 0);
        check("post_reset_write", bus.count, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
